clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Run-time programmable clock-divider controller.
- Owns the divide counter and the output waveform, and sequences start, stop and ratio changes so they take effect only at output-period boundaries. This keeps the divided clock free of runt pulses.
- Sits between the CPU/config bus and every consumer of a divided clock or clock-enable in the SoC.

Parameters:
- DIV_W, 8, width of divisor and period counter.
- DEF_DIV, 20, divisor loaded at reset (must satisfy 2 <= DEF_DIV <= 2^DIV_W-1).

Ports:
- clk_in  in  1  source clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  run request: 1 = run, 0 = stop at the next period boundary.
- cfg_valid_i  in  1  new divisor offered.
- cfg_div_i  in  DIV_W  new divisor value.
- cfg_ready_o  out  1  pending slot empty; transfer happens when valid && ready.
- clk_out  out  1  divided clock, registered.
- tick_o  out  1  one-cycle pulse coincident with each clk_out rising period start.
- busy_o  out  1  state != STOP.
- err_o  out  1  one-cycle pulse when an accepted divisor is < 2.
- cur_div_o  out  DIV_W  divisor currently in effect.
- period_cnt_o  out  16  completed-period count (optional feature).

Behaviour:
- Reset values: state=STOP, cnt=0, cur_div=DEF_DIV, pending empty, clk_out=0, tick_o=0, err_o=0, busy_o=0, cfg_ready_o=1, period_cnt_o=0.
- Reset is asynchronous; assertion mid-period forces clk_out=0 immediately and discards any pending divisor.
- Period counter runs 0..cur_div-1 and then wraps to 0. The cycle with cnt==cur_div-1 is the "boundary".
- Waveform:
  - H = cur_div>>1.
  - clk_out=1 while cnt<H, else 0.
  - clk_out and cnt are registered together, so there is no combinational path to clk_out.
  - Even divisors give 50% duty; odd divisors give low phase one cycle longer than high.
  - tick_o=1 in the cycle where cnt==0 and state is RUN.
- States:
  - STOP: cnt held at 0, clk_out=0. When en_i=1, go to RUN; the next cycle has cnt=0, clk_out=1, tick_o=1 (1-cycle start latency).
  - RUN: counting. If en_i=0 is sampled at any point, go to DRAIN, except at the boundary, where the block goes directly to STOP.
  - DRAIN: keep counting to the boundary, then go to STOP. en_i returning to 1 during DRAIN returns to RUN with no waveform disturbance.
- Divisor handshake:
  - A transfer occurs on cfg_valid_i && cfg_ready_o.
  - If value >= 2, it is stored in the pending slot and cfg_ready_o drops the next cycle.
  - If value < 2, it is dropped, err_o pulses the next cycle, and cfg_ready_o stays 1.
- Applying a pending divisor:
  - In STOP it applies the cycle after capture.
  - In RUN/DRAIN it applies at the first boundary strictly after the capture cycle. A transfer in the boundary cycle itself waits one full period.
  - On apply: cur_div updates, cnt wraps to 0, pending clears, and cfg_ready_o returns to 1 the next cycle.
- Simultaneous stop request and apply at one boundary: both take effect, so the block enters STOP with the new cur_div.
- Only one divisor can be outstanding; there is no queueing beyond the pending slot.

Optional Feature:
- CLK_DIV_PERIOD_CNT_EN defined:
  - period_cnt_o increments at every boundary while in RUN/DRAIN.
  - It saturates at 16'hFFFF and clears when going from STOP to RUN.
- Undefined: period_cnt_o is tied to 0 and no counter register is built.

Decomposition:
- Package clk_div_pkg holds:
  - MIN_DIV=2.
  - State enum {STOP, RUN, DRAIN}.
  - Width constant for period_cnt (16).
- Natural sub-module: clk_div_core, containing cnt, the waveform register and tick generation, with inputs run, load and div.
- clk_div_ctrl keeps the FSM, the handshake/pending slot, the error logic and the optional counter.

Test Plan:
- Reset-run default: release rst_n, en_i=1 → clk_out period 20 cycles with 10 high/10 low; tick_o every 20 cycles; cur_div_o=20.
- Ratio change mid-period: RUN div=20, write 6 at cnt=5 → current 20-cycle period completes intact, then period=6 (3/3); cfg_ready_o low from capture until apply.
- Odd divisor: write 5 → high 2, low 3 each period; tick_o at each rise.
- Illegal divisor: write 1, then 0 → err_o pulses once each, cur_div unchanged, cfg_ready_o stays 1.
- Stop/restart: drop en_i at cnt=3 (div=8) → clk_out finishes the period and stays 0, busy_o falls after the boundary; en_i=1 → restarts with clk_out=1 after one cycle.
- Async reset at cnt=7 with a pending divisor → clk_out=0 immediately; after release cur_div=20, pending empty; with CLK_DIV_PERIOD_CNT_EN, period_cnt_o=0 and it increments to 3 after 3 periods.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and state type for the clock-divider controller.
//   MIN_DIV - smallest legal divisor
//   PCNT_W  - width of the completed-period counter
//   state_t - controller states STOP / RUN / DRAIN
package clk_div_pkg;
    localparam int MIN_DIV = 2;
    localparam int PCNT_W  = 16;
    typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, divisor register and registered waveform/tick.
//   clk_in   in   source clock
//   rst_n    in   asynchronous active-low reset
//   run      in   block is running in the next cycle
//   load     in   take div as the new divisor at this edge
//   div      in   divisor to load
//   cur_div  out  divisor currently in effect
//   clk_out  out  divided clock (registered)
//   tick     out  pulse in the first cycle of each running period
//   boundary out  last cycle of a running period
module clk_div_core #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 20
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick,
    output logic             boundary
);
    logic             act;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] nxt_div;

    assign boundary = act && (cnt == cur_div - DIV_W'(1));
    assign nxt_div  = load ? div : cur_div;
    // A start from idle and every wrap both begin the period at zero.
    assign nxt_cnt  = (!run || !act || boundary) ? '0 : cnt + DIV_W'(1);

    // Waveform is derived from the next count so clk_out lines up with cnt.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            act     <= 1'b0;
            cnt     <= '0;
            cur_div <= DIV_W'(DEF_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act     <= run;
            cnt     <= nxt_cnt;
            cur_div <= nxt_div;
            clk_out <= run && (nxt_cnt < (nxt_div >> 1));
            tick    <= run && (nxt_cnt == '0);
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable clock divider with glitch-free start/stop/ratio change.
//   clk_in        in   source clock
//   rst_n         in   asynchronous active-low reset
//   en_i          in   run request (0 = stop at the next period boundary)
//   cfg_valid_i   in   new divisor offered
//   cfg_div_i     in   new divisor value
//   cfg_ready_o   out  pending slot empty
//   clk_out       out  divided clock
//   tick_o        out  pulse at each period start
//   busy_o        out  not stopped
//   err_o         out  pulse after an accepted divisor below MIN_DIV
//   cur_div_o     out  divisor in effect
//   period_cnt_o  out  completed periods (only with CLK_DIV_PERIOD_CNT_EN, else 0)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 20
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              cfg_valid_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic              cfg_ready_o,
    output logic              clk_out,
    output logic              tick_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [DIV_W-1:0]  cur_div_o,
    output logic [PCNT_W-1:0] period_cnt_o
);
    state_t           state;
    state_t           nstate;
    logic             pend;
    logic [DIV_W-1:0] pend_div;
    logic             boundary;
    logic             accept;
    logic             legal;
    logic             apply;
    logic             run;

    assign accept      = cfg_valid_i && !pend;
    assign legal       = cfg_div_i >= DIV_W'(MIN_DIV);
    // Idle applies immediately; running waits for the end of the current period.
    assign apply       = pend && (state == STOP || boundary);
    assign cfg_ready_o = !pend;
    assign busy_o      = state != STOP;
    assign run         = nstate != STOP;

    always_comb begin
        nstate = state == STOP ? (en_i ? RUN : STOP) :
                 en_i          ? RUN :
                 boundary      ? STOP : DRAIN;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STOP;
            pend     <= 1'b0;
            pend_div <= DIV_W'(DEF_DIV);
            err_o    <= 1'b0;
        end else begin
            state <= nstate;
            err_o <= accept && !legal;
            if (apply) begin
                pend <= 1'b0;
            end else if (accept && legal) begin
                pend     <= 1'b1;
                pend_div <= cfg_div_i;
            end
        end
    end

    clk_div_core #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_core (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (run),
        .load     (apply),
        .div      (pend_div),
        .cur_div  (cur_div_o),
        .clk_out  (clk_out),
        .tick     (tick_o),
        .boundary (boundary)
    );

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [PCNT_W-1:0] pcnt;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (state == STOP && run) begin
            pcnt <= '0;
        end else if (boundary && pcnt != '1) begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end
    assign period_cnt_o = pcnt;
`else
    assign period_cnt_o = '0;
`endif
endmodule
